mac_learn_table: RTL and testbench

Parametrised next-generation MAC learning/forwarding table for the switch datapath. Behaviour per request:
- Looks up the destination MAC and returns either the egress port or a flood mask.
- Learns the source MAC against its ingress port.
- Handles station moves, per-entry aging, table-full drop, flush and same-port filtering.
- Uses a valid/ready request/response handshake in place of free-running per-cycle lookup.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_cam_match.sv | 33 +++
 rtl/mac_learn_table.sv | 175 +++++++++++++++++
 tb/tb_mac_learn_table.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC learning table.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int unsigned MAX_ADDR_WIDTH = 64;

  // I/G bit sits in the lowest bit of the first transmitted octet.
  function automatic logic is_multicast(input logic [MAX_ADDR_WIDTH-1:0] addr,
                                        input int unsigned addr_width);
    logic [MAX_ADDR_WIDTH-1:0] sh;
    sh = addr >> (addr_width - 8);
    return sh[0];
  endfunction

endpackage

// File: rtl/mac_cam_match.sv
// Parallel compare of one key against every table entry; lowest index wins.
module mac_cam_match #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned IW        = $clog2(DEPTH)
) (
  input  logic [ADDR_WIDTH-1:0] key,
  input  logic [DEPTH-1:0]      valid,
  input  logic [ADDR_WIDTH-1:0] macs [DEPTH],
  output logic                  hit_c,
  output logic [IW-1:0]         hit_idx_c,
  output logic                  free_c,
  output logic [IW-1:0]         free_idx_c
);

  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid[i] && (macs[i] == key)) begin
        hit_c     = 1'b1;
        hit_idx_c = IW'(i);
      end
      if (!valid[i]) begin
        free_c     = 1'b1;
        free_idx_c = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mac_learn_table.sv
// MAC learning/forwarding table with valid/ready request/response handshake,
// per-entry aging, station moves, flush and same-port filtering.
module mac_learn_table
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NUM_PORTS  = 16,
  parameter int unsigned AGE_WIDTH  = 8,
  localparam int unsigned PW        = $clog2(NUM_PORTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        dst_addr,
  input  logic [ADDR_WIDTH-1:0]        src_addr,
  input  logic [PW-1:0]                src_port,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_hit,
  output logic [PW-1:0]                resp_port,
  output logic [NUM_PORTS-1:0]         resp_fwd_mask,
  input  logic                         age_tick,
  input  logic                         flush,
  output logic                         learn_full,
  output logic [$clog2(DEPTH+1)-1:0]   entry_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] mac;
    logic [PW-1:0]         port;
    logic [AGE_WIDTH-1:0]  age;
  } entry_t;

  state_e                state_q, state_d;
  logic                  cap, do_lookup;
  logic [ADDR_WIDTH-1:0] dst_q, src_q;
  logic [PW-1:0]         sport_q;
  logic [DEPTH-1:0]      valid_q, valid_d;
  entry_t                tbl_q [DEPTH];
  logic [ADDR_WIDTH-1:0] mac_c [DEPTH];
  logic [CW-1:0]         count_d;

  logic                  d_hit, s_hit, s_free;
  logic [IW-1:0]         d_idx, s_idx, s_free_idx;
  logic                  unused_dst_free;
  logic [IW-1:0]         unused_dst_free_idx;

  logic                  hit_d;
  logic [PW-1:0]         port_d;
  logic [NUM_PORTS-1:0]  mask_d, flood;
  logic                  src_ok, learn_en, wr_en, full_d;
  logic [IW-1:0]         wr_idx;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) mac_c[i] = tbl_q[i].mac;
  end

  mac_cam_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_dst_match (
    .key(dst_q), .valid(valid_q), .macs(mac_c),
    .hit_c(d_hit), .hit_idx_c(d_idx),
    .free_c(unused_dst_free), .free_idx_c(unused_dst_free_idx)
  );

  mac_cam_match #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_src_match (
    .key(src_q), .valid(valid_q), .macs(mac_c),
    .hit_c(s_hit), .hit_idx_c(s_idx),
    .free_c(s_free), .free_idx_c(s_free_idx)
  );

  // Next-state logic: accept in IDLE, one lookup cycle, hold response until consumed.
  always_comb begin
    state_d   = state_q;
    cap       = 1'b0;
    do_lookup = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_LOOKUP;
          cap     = 1'b1;
        end
      end
      ST_LOOKUP: begin
        state_d   = ST_RESP;
        do_lookup = 1'b1;
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Destination lookup against the pre-learn table contents.
  always_comb begin
    flood  = ~(NUM_PORTS'(1) << sport_q);
    hit_d  = 1'b0;
    port_d = '0;
    mask_d = flood;
    if (!is_multicast(64'(dst_q), ADDR_WIDTH) && d_hit) begin
      hit_d  = 1'b1;
      port_d = tbl_q[d_idx].port;
      mask_d = (port_d == sport_q) ? '0 : (NUM_PORTS'(1) << port_d);
    end
  end

  // A source hit always reuses its entry, so duplicates cannot form.
  assign src_ok   = !is_multicast(64'(src_q), ADDR_WIDTH) && (src_q != '0);
  assign learn_en = do_lookup && !flush && src_ok;
  assign wr_en    = learn_en && (s_hit || s_free);
  assign wr_idx   = s_hit ? s_idx : s_free_idx;
  assign full_d   = learn_en && !s_hit && !s_free;

  // Priority: flush over learn over aging expiry.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (age_tick && valid_q[i] && (tbl_q[i].age == AGE_WIDTH'(1))) valid_d[i] = 1'b0;
    end
    if (wr_en) valid_d[wr_idx] = 1'b1;
    if (flush) valid_d = '0;
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) count_d = count_d + CW'(valid_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_port     <= '0;
      resp_fwd_mask <= '0;
      learn_full    <= 1'b0;
      valid_q       <= '0;
      entry_count   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready   <= (state_d == ST_IDLE);
      resp_valid  <= (state_d == ST_RESP);
      learn_full  <= full_d;
      valid_q     <= valid_d;
      entry_count <= count_d;
      if (do_lookup) begin
        resp_hit      <= hit_d;
        resp_port     <= port_d;
        resp_fwd_mask <= mask_d;
      end
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      dst_q   <= dst_addr;
      src_q   <= src_addr;
      sport_q <= src_port;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (wr_en && (wr_idx == IW'(i))) begin
        tbl_q[i].mac  <= src_q;
        tbl_q[i].port <= sport_q;
        tbl_q[i].age  <= AGE_MAX;
      end else if (age_tick && valid_q[i]) begin
        tbl_q[i].age <= tbl_q[i].age - AGE_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_learn_table.sv
// Directed bench for mac_learn_table (16 entries, 16 ports, 2-bit age).
module tb_mac_learn_table;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, resp_valid, resp_ready;
  logic [47:0] dst_addr, src_addr;
  logic [3:0]  src_port, resp_port;
  logic        resp_hit, age_tick, flush, learn_full;
  logic [15:0] resp_fwd_mask;
  logic [4:0]  entry_count;

  int nvec = 0;
  int nerr = 0;

  localparam logic [47:0] A1 = 48'h0A0000000001;
  localparam logic [47:0] A2 = 48'h0A0000000002;
  localparam logic [47:0] A3 = 48'h0A0000000003;
  localparam logic [47:0] MC = 48'h01005E000001;
  localparam logic [47:0] B1 = 48'h0A0000000100;
  localparam logic [47:0] C1 = 48'h0A0000000200;
  localparam logic [47:0] C2 = 48'h0A0000000201;
  localparam logic [47:0] Z  = 48'h0;

  always #5 clk = ~clk;

  mac_learn_table #(
    .ADDR_WIDTH(48), .DEPTH(16), .NUM_PORTS(16), .AGE_WIDTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .dst_addr(dst_addr), .src_addr(src_addr), .src_port(src_port),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_port(resp_port), .resp_fwd_mask(resp_fwd_mask),
    .age_tick(age_tick), .flush(flush),
    .learn_full(learn_full), .entry_count(entry_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; optional age_tick/flush strobes land in the LOOKUP cycle.
  // Returns one time step after the edge that enters RESP.
  task automatic send(input logic [47:0] d, input logic [47:0] s, input logic [3:0] p,
                      input logic tick_lk, input logic flush_lk);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    dst_addr  = d;
    src_addr  = s;
    src_port  = p;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    age_tick = tick_lk;
    flush    = flush_lk;
    chk("lookup_no_resp", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1 age_tick = 1'b0;
    flush = 1'b0;
    n = 0;
    while (!resp_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_latency", 64'(n), 64'd0);
  endtask

  task automatic rsp(input string tag, input logic hit, input logic [3:0] port,
                     input logic [15:0] mask, input int cnt);
    chk({tag, ".hit"}, 64'(resp_hit), 64'(hit));
    if (hit) chk({tag, ".port"}, 64'(resp_port), 64'(port));
    chk({tag, ".mask"}, 64'(resp_fwd_mask), 64'(mask));
    chk({tag, ".count"}, 64'(entry_count), 64'(cnt));
  endtask

  task automatic tick(input string tag, input int cnt);
    @(negedge clk);
    age_tick = 1'b1;
    @(negedge clk);
    age_tick = 1'b0;
    chk(tag, 64'(entry_count), 64'(cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; age_tick = 1'b0; flush = 1'b0;
    dst_addr = '0; src_addr = '0; src_port = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_hit", 64'(resp_hit), 64'd0);
    chk("rst.resp_port", 64'(resp_port), 64'd0);
    chk("rst.mask", 64'(resp_fwd_mask), 64'd0);
    chk("rst.learn_full", 64'(learn_full), 64'd0);
    chk("rst.count", 64'(entry_count), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Miss floods everything but the ingress port; source learned.
    send(A1, A2, 4'd3, 1'b0, 1'b0);
    rsp("s1", 1'b0, 4'd0, 16'hFFF7, 1);
    chk("s1.learn_full", 64'(learn_full), 64'd0);

    // Hit, then same-port filter; all-zero src is not learned.
    send(A2, Z, 4'd5, 1'b0, 1'b0);
    rsp("s2", 1'b1, 4'd3, 16'h0008, 1);
    send(A2, Z, 4'd3, 1'b0, 1'b0);
    rsp("s2filt", 1'b1, 4'd3, 16'h0000, 1);

    // Station move keeps the count; lookup sees pre-learn table.
    send(Z, A2, 4'd7, 1'b0, 1'b0);
    rsp("s3move", 1'b0, 4'd0, 16'hFF7F, 1);
    send(A2, Z, 4'd1, 1'b0, 1'b0);
    rsp("s3", 1'b1, 4'd7, 16'h0080, 1);
    send(A3, A3, 4'd2, 1'b0, 1'b0);
    rsp("s3pre", 1'b0, 4'd0, 16'hFFFB, 2);

    // Fill the table, then overflow once.
    for (int i = 0; i < 14; i++) begin
      send(Z, 48'h0A0000000010 + 48'(i), 4'd4, 1'b0, 1'b0);
      chk("fill.count", 64'(entry_count), 64'(3 + i));
    end
    send(Z, 48'h0A00000000FF, 4'd4, 1'b0, 1'b0);
    chk("full.learn_full", 64'(learn_full), 64'd1);
    chk("full.count", 64'(entry_count), 64'd16);
    @(posedge clk);
    #1 chk("full.pulse_end", 64'(learn_full), 64'd0);
    send(A3, A2, 4'd7, 1'b0, 1'b0);
    rsp("s4refresh", 1'b1, 4'd2, 16'h0004, 16);
    chk("s4refresh.learn_full", 64'(learn_full), 64'd0);
    send(MC, MC, 4'd9, 1'b0, 1'b0);
    rsp("s4mcast", 1'b0, 4'd0, 16'hFDFF, 16);
    chk("s4mcast.learn_full", 64'(learn_full), 64'd0);

    // All 16 entries expire together on the third tick.
    tick("age.t1", 16);
    tick("age.t2", 16);
    tick("age.t3", 0);

    // Refresh in the same cycle as a tick that would have expired the entry.
    send(Z, B1, 4'd6, 1'b0, 1'b0);
    rsp("s5learn", 1'b0, 4'd0, 16'hFFBF, 1);
    tick("age.b1", 1);
    tick("age.b2", 1);
    send(Z, B1, 4'd6, 1'b1, 1'b0);
    rsp("s5win", 1'b0, 4'd0, 16'hFFBF, 1);
    tick("age.w1", 1);
    tick("age.w2", 1);
    tick("age.w3", 0);

    // Flush during LOOKUP: response still from old table, learn dropped.
    send(Z, C1, 4'd2, 1'b0, 1'b0);
    rsp("s6pre", 1'b0, 4'd0, 16'hFFFB, 1);
    send(C1, C2, 4'd5, 1'b0, 1'b1);
    rsp("s6flush", 1'b1, 4'd2, 16'h0004, 0);
    send(C2, Z, 4'd4, 1'b0, 1'b0);
    rsp("s6nolearn", 1'b0, 4'd0, 16'hFFEF, 0);

    // Idle flush clears a populated table.
    send(Z, C1, 4'd2, 1'b0, 1'b0);
    send(Z, C2, 4'd3, 1'b0, 1'b0);
    chk("idleflush.pre", 64'(entry_count), 64'd2);
    @(negedge clk) flush = 1'b1;
    @(negedge clk) flush = 1'b0;
    chk("idleflush.count", 64'(entry_count), 64'd0);

    // Reset while a response is pending.
    send(Z, C1, 4'd2, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rstresp.resp_valid", 64'(resp_valid), 64'd0);
    chk("rstresp.req_ready", 64'(req_ready), 64'd1);
    chk("rstresp.count", 64'(entry_count), 64'd0);
    @(negedge clk) reset = 1'b1;
    send(C1, Z, 4'd1, 1'b0, 1'b0);
    rsp("postrst", 1'b0, 4'd0, 16'hFFFD, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
